// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - 5x5 mine map generator (LFSR rejection sampling, fallback fill); optional MINE_PLACER_EXCLUDE_EN
module mine_placer #(
    parameter int          N_CELLS   = 25,
    parameter int          N_MINES   = 3,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 255
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
`ifdef MINE_PLACER_EXCLUDE_EN
    input  logic [4:0]  exclude_cell,
`endif
    output logic [24:0] mines,
    output logic        place_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [4:0]  LAST_IDX    = 5'(N_CELLS - 1);
    localparam logic [4:0]  CELLS_C     = 5'(N_CELLS);
    localparam logic [4:0]  N_MINES_C   = 5'(N_MINES);
    localparam logic [7:0]  MAX_TRIES_C = 8'(MAX_TRIES);
    localparam logic [15:0] LFSR_MASK   = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [24:0] mines_q, mines_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  tries_q, tries_d;
    logic [4:0]  idx_q, idx_d;

    logic [4:0]  cand;
    logic [24:0] cand_oh;
    logic [24:0] idx_oh;
    logic        cand_excl;
    logic        idx_excl;
    logic        busy_w;

    assign cand    = lfsr_q[4:0];
    assign cand_oh = 25'd1 << cand;
    assign idx_oh  = 25'd1 << idx_q;
    assign busy_w  = (state_q == S_DRAW) || (state_q == S_FILL);

`ifdef MINE_PLACER_EXCLUDE_EN
    logic [4:0] excl_q, excl_d;
    assign cand_excl = (cand == excl_q);
    assign idx_excl  = (idx_q == excl_q);
`else
    assign cand_excl = 1'b0;
    assign idx_excl  = 1'b0;
`endif

    // Next-state logic: LFSR stepping/seeding and the placement FSM.
    always_comb begin
        state_d = state_q;
        mines_d = mines_q;
        count_d = count_q;
        tries_d = tries_q;
        idx_d   = idx_q;
`ifdef MINE_PLACER_EXCLUDE_EN
        excl_d  = excl_q;
`endif
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        if (seed_load && !busy_w) begin
            lfsr_d = (seed == 16'h0000) ? SEED : seed;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRAW;
                    mines_d = '0;
                    count_d = '0;
                    tries_d = '0;
                    idx_d   = '0;
`ifdef MINE_PLACER_EXCLUDE_EN
                    excl_d  = exclude_cell;
`endif
                end
            end
            S_DRAW: begin
                tries_d = tries_q + 8'd1;
                if ((cand < CELLS_C) && ((mines_q & cand_oh) == '0) && !cand_excl) begin
                    mines_d = mines_q | cand_oh;
                    count_d = count_q + 5'd1;
                end
                if (count_d == N_MINES_C) begin
                    state_d = S_DONE;
                end else if (tries_d == MAX_TRIES_C) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Deterministic fallback: lowest clear, non-excluded cells first.
                if (((mines_q & idx_oh) == '0) && !idx_excl) begin
                    mines_d = mines_q | idx_oh;
                    count_d = count_q + 5'd1;
                end
                idx_d = idx_q + 5'd1;
                if ((count_d == N_MINES_C) || (idx_q == LAST_IDX)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous abort on restart_n.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            mines_q <= '0;
            count_q <= '0;
            tries_q <= '0;
            idx_q   <= '0;
`ifdef MINE_PLACER_EXCLUDE_EN
            excl_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mines_q <= mines_d;
            count_q <= count_d;
            tries_q <= tries_d;
            idx_q   <= idx_d;
`ifdef MINE_PLACER_EXCLUDE_EN
            excl_q  <= excl_d;
`endif
        end
    end

    assign mines      = mines_q;
    assign place_done = (state_q == S_DONE);
    assign busy       = busy_w;

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
Generates the random mine map for a new 5x5 game and feeds the datapath, which consumes `mines` and `place_done`.
- A 16-bit Galois LFSR proposes cell indices.
- Rejection sampling keeps only valid, unused cells until N_MINES distinct mines are placed.
- A bounded-retry watchdog guarantees termination with a deterministic fallback fill.

Parameters:
N_CELLS, 25, number of board cells; fixed at 25 (5-bit index, 25-bit map).
N_MINES, 3, mines to place; legal range 1..24.
SEED, 16'hACE1, LFSR reset value and substitute for a zero seed.
MAX_TRIES, 255, random draws allowed per placement before fallback; 8-bit counter.

Ports:
clka  input  1  single clock; all state changes on posedge.
restart_n  input  1  asynchronous active-low reset.
start  input  1  request a new placement; level, sampled each cycle.
seed_load  input  1  load `seed` into LFSR when not busy.
seed  input  16  seed value.
mines  output  25  mine map, bit i = cell i mined.
place_done  output  1  map valid; level.
busy  output  1  placement in progress.

Behaviour:
- Reset (restart_n low, asynchronous):
  - outputs: mines=0, place_done=0, busy=0.
  - internal: lfsr=SEED, state=IDLE, count=0, tries=0.
  - Mid-operation reset aborts immediately; there is no partial map.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shifts right every cycle in every state except when loaded.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Seed load:
  - Applies only when busy=0.
  - seed_load=1 sets lfsr=seed, or lfsr=SEED if seed==0.
  - seed_load while busy is ignored.
  - If seed_load and start are in the same cycle: the seed loads that cycle, and the start is accepted the same cycle.
- State machine (IDLE, DRAW, FILL, DONE):
  - IDLE/DONE, start=1 → DRAW next cycle.
    - On acceptance: mines=0, count=0, tries=0, place_done=0, busy=1.
  - DRAW, each cycle:
    - cand = lfsr[4:0]; tries increments.
    - If cand<25 and mines[cand]==0: set mines[cand], count+1.
    - Otherwise reject; there is no change to mines.
    - If count reaches N_MINES (including this cycle's accept) → DONE.
    - Else if tries reaches MAX_TRIES → FILL.
  - FILL: scans index from 0 upward, one cell per cycle.
    - Sets each clear bit until count==N_MINES → DONE.
    - Scanning stops at index 24 at most.
  - DONE: place_done=1 and busy=0, held until the next accepted start or reset. mines held stable.
- start while busy (DRAW/FILL) is ignored; there is no restart of placement.
- Latency:
  - Minimum N_MINES cycles from acceptance to place_done, with place_done asserted the cycle after the final accept.
  - Maximum MAX_TRIES + 25 + 1 cycles.
- Invariants:
  - popcount(mines)==N_MINES whenever place_done=1.
  - mines never changes while place_done=1.
  - Result is deterministic for a given seed and cycle of start.

Optional Feature:
MINE_PLACER_EXCLUDE_EN
- Defined:
  - Adds input `exclude_cell` [4:0], sampled at start acceptance and held internally.
  - DRAW rejects cand==held value; FILL skips it.
  - Used so the first opened cell is never a mine.
  - An exclude_cell value >=25 excludes nothing.
- Undefined: no port; every cell 0..24 is eligible.

Test Plan:
1. Reset then idle 10 cycles → mines=0, place_done=0, busy=0. Assert restart_n low asynchronously mid-DRAW → all outputs 0 without a clock edge.
2. seed_load with seed=16'h0001, then start → place_done rises within MAX_TRIES+26 cycles. Check:
   - popcount(mines)==3; no bit >24.
   - mines matches the reference-model LFSR trace.
   - Repeat with the same seed → identical mines.
3. Pulse start repeatedly during DRAW → ignored; result equals the single-start run. seed_load during DRAW → lfsr unaffected.
4. N_MINES=24, MAX_TRIES=1 → FILL engages. Check:
   - Final mines has exactly one clear bit.
   - place_done=1, busy=0.
5. seed=16'h0000 load → behaves identically to a SEED (16'hACE1) load; the LFSR never sticks at zero.
6. With MINE_PLACER_EXCLUDE_EN, exclude_cell=5'd12, N_MINES=24, 20 different seeds → mines==~(25'b1<<12) every run.
